// File: rtl/ascon_ctrl_fsm.sv
// Sequencing controller for the ASCON-128 permutation datapath: one round per clock
// through init p^a, AD/PT absorption p^b, finalisation p^a and tag release.
module ascon_ctrl_fsm #(
   parameter int unsigned ROUNDS_A  = 12,
   parameter int unsigned ROUNDS_B  = 6,
   parameter int unsigned BLK_CNT_W = 8
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [BLK_CNT_W-1:0] ad_nb_i,
   input  logic [BLK_CNT_W-1:0] pt_nb_i,
   input  logic                 block_valid_i,
   output logic                 block_ready_o,
   output logic [3:0]           round_o,
   output logic                 input_mode_o,
   output logic                 enable_state_o,
   output logic                 xor_begin_data_o,
   output logic                 xor_begin_key_o,
   output logic                 bypass_xor_end_o,
   output logic                 mode_xor_key_o,
   output logic                 cipher_valid_o,
   output logic                 tag_valid_o,
   output logic                 busy_o
);

   localparam logic [3:0] RND_LAST = 4'(ROUNDS_A - 1);
   localparam logic [3:0] RND_B0   = 4'(12 - ROUNDS_B);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_AD_WAIT = 3'd2;
   localparam logic [2:0] S_AD_RUN  = 3'd3;
   localparam logic [2:0] S_PT_WAIT = 3'd4;
   localparam logic [2:0] S_PT_RUN  = 3'd5;
   localparam logic [2:0] S_FINAL   = 3'd6;
   localparam logic [2:0] S_TAG     = 3'd7;

   logic [2:0]           state, state_d;
   logic [3:0]           rnd, rnd_d;
   logic [BLK_CNT_W-1:0] ad_cnt, ad_cnt_d;
   logic [BLK_CNT_W-1:0] pt_cnt, pt_cnt_d;
   logic                 pt_last;

   assign pt_last = (pt_cnt == BLK_CNT_W'(1));

   // State and counter registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state  <= S_IDLE;
         rnd    <= 4'd0;
         ad_cnt <= '0;
         pt_cnt <= '0;
      end else begin
         state  <= state_d;
         rnd    <= rnd_d;
         ad_cnt <= ad_cnt_d;
         pt_cnt <= pt_cnt_d;
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      state_d          = state;
      rnd_d            = rnd;
      ad_cnt_d         = ad_cnt;
      pt_cnt_d         = pt_cnt;
      block_ready_o    = 1'b0;
      round_o          = 4'd0;
      input_mode_o     = 1'b1;
      enable_state_o   = 1'b0;
      xor_begin_data_o = 1'b0;
      xor_begin_key_o  = 1'b0;
      bypass_xor_end_o = 1'b1;
      mode_xor_key_o   = 1'b0;
      cipher_valid_o   = 1'b0;
      tag_valid_o      = 1'b0;
      busy_o           = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            if (start_i && (ad_nb_i != '0) && (pt_nb_i != '0)) begin
               ad_cnt_d = ad_nb_i;
               pt_cnt_d = pt_nb_i;
               rnd_d    = 4'd0;
               state_d  = S_INIT;
            end
         end
         S_INIT: begin
            enable_state_o = 1'b1;
            round_o        = rnd;
            input_mode_o   = (rnd != 4'd0);
            if (rnd == RND_LAST) begin
               bypass_xor_end_o = 1'b0;
               mode_xor_key_o   = 1'b1;
               state_d          = S_AD_WAIT;
            end else begin
               rnd_d = rnd + 4'd1;
            end
         end
         S_AD_WAIT: begin
            block_ready_o = 1'b1;
            round_o       = RND_B0;
            if (block_valid_i) begin
               xor_begin_data_o = 1'b1;
               enable_state_o   = 1'b1;
               ad_cnt_d         = (ad_cnt != '0) ? ad_cnt - BLK_CNT_W'(1) : ad_cnt;
               rnd_d            = RND_B0 + 4'd1;
               state_d          = S_AD_RUN;
            end
         end
         S_AD_RUN: begin
            enable_state_o = 1'b1;
            round_o        = rnd;
            if (rnd == RND_LAST) begin
               // Domain separation after the last AD block
               if (ad_cnt == '0) begin
                  bypass_xor_end_o = 1'b0;
                  state_d          = S_PT_WAIT;
               end else begin
                  state_d = S_AD_WAIT;
               end
            end else begin
               rnd_d = rnd + 4'd1;
            end
         end
         S_PT_WAIT: begin
            block_ready_o = 1'b1;
            round_o       = pt_last ? 4'd0 : RND_B0;
            if (block_valid_i) begin
               xor_begin_data_o = 1'b1;
               cipher_valid_o   = 1'b1;
               enable_state_o   = 1'b1;
               pt_cnt_d         = (pt_cnt != '0) ? pt_cnt - BLK_CNT_W'(1) : pt_cnt;
               if (pt_last) begin
                  xor_begin_key_o = 1'b1;
                  rnd_d           = 4'd1;
                  state_d         = S_FINAL;
               end else begin
                  rnd_d   = RND_B0 + 4'd1;
                  state_d = S_PT_RUN;
               end
            end
         end
         S_PT_RUN: begin
            enable_state_o = 1'b1;
            round_o        = rnd;
            if (rnd == RND_LAST) begin
               state_d = S_PT_WAIT;
            end else begin
               rnd_d = rnd + 4'd1;
            end
         end
         S_FINAL: begin
            enable_state_o = 1'b1;
            round_o        = rnd;
            if (rnd == RND_LAST) begin
               bypass_xor_end_o = 1'b0;
               mode_xor_key_o   = 1'b1;
               state_d          = S_TAG;
            end else begin
               rnd_d = rnd + 4'd1;
            end
         end
         S_TAG: begin
            tag_valid_o = 1'b1;
            rnd_d       = 4'd0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: table of whole transactions with hand-computed
// cycle counts, plus hand-written sequences for zero-count start and mid-run reset.
module tb_ascon_ctrl_fsm;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic [7:0] ad_nb_i;
   logic [7:0] pt_nb_i;
   logic       block_valid_i;
   logic       block_ready_o;
   logic [3:0] round_o;
   logic       input_mode_o;
   logic       enable_state_o;
   logic       xor_begin_data_o;
   logic       xor_begin_key_o;
   logic       bypass_xor_end_o;
   logic       mode_xor_key_o;
   logic       cipher_valid_o;
   logic       tag_valid_o;
   logic       busy_o;

   int n_checks = 0;
   int n_errors = 0;

   ascon_ctrl_fsm dut (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .start_i          (start_i),
      .ad_nb_i          (ad_nb_i),
      .pt_nb_i          (pt_nb_i),
      .block_valid_i    (block_valid_i),
      .block_ready_o    (block_ready_o),
      .round_o          (round_o),
      .input_mode_o     (input_mode_o),
      .enable_state_o   (enable_state_o),
      .xor_begin_data_o (xor_begin_data_o),
      .xor_begin_key_o  (xor_begin_key_o),
      .bypass_xor_end_o (bypass_xor_end_o),
      .mode_xor_key_o   (mode_xor_key_o),
      .cipher_valid_o   (cipher_valid_o),
      .tag_valid_o      (tag_valid_o),
      .busy_o           (busy_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      int ad;
      int pt;
      int ad_stall;
      int pt_stall;
      bit restart;
      int exp_tag;
      int exp_hs;
      int exp_cv;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle(input string pfx);
      check({pfx, "_ready"},      32'(block_ready_o),    0);
      check({pfx, "_round"},      32'(round_o),          0);
      check({pfx, "_input_mode"}, 32'(input_mode_o),     1);
      check({pfx, "_enable"},     32'(enable_state_o),   0);
      check({pfx, "_xb_data"},    32'(xor_begin_data_o), 0);
      check({pfx, "_xb_key"},     32'(xor_begin_key_o),  0);
      check({pfx, "_bypass"},     32'(bypass_xor_end_o), 1);
      check({pfx, "_mode_key"},   32'(mode_xor_key_o),   0);
      check({pfx, "_cipher"},     32'(cipher_valid_o),   0);
      check({pfx, "_tag"},        32'(tag_valid_o),      0);
      check({pfx, "_busy"},       32'(busy_o),           0);
   endtask

   // One full transaction from a start pulse; block_valid_i is random outside WAIT states
   task automatic run_txn(input vec_t v, input string nm);
      int exp_q[$];
      int got_q[$];
      int hs = 0, cv = 0, xe = 0, busy_n = 0, tag_cyc = 0;
      int ad_left, pt_left, bad_rnd = 0, bad_wait = 0;
      logic [2:0] modes = 3'b000;
      logic [3:0] prev_rnd = 4'd0;
      bit prev_stall = 0;
      bit stall;

      for (int r = 0; r < 12; r++) exp_q.push_back(r);
      for (int b = 0; b < v.ad + v.pt - 1; b++)
         for (int r = 6; r < 12; r++) exp_q.push_back(r);
      for (int r = 0; r < 12; r++) exp_q.push_back(r);

      ad_left = v.ad_stall;
      pt_left = v.pt_stall;
      @(negedge clock_i);
      ad_nb_i = 8'(v.ad);
      pt_nb_i = 8'(v.pt);
      start_i = 1'b1;
      block_valid_i = 1'b0;
      @(posedge clock_i);
      #1;
      start_i = 1'b0;
      ad_nb_i = 8'd7;
      pt_nb_i = 8'd9;
      for (int cyc = 1; cyc <= 300 && tag_cyc == 0; cyc++) begin
         start_i = (v.restart && (cyc == 3 || cyc == 8)) ? 1'b1 : 1'b0;
         stall = 0;
         if (block_ready_o) begin
            if (hs < v.ad && ad_left > 0) begin
               stall = 1;
               ad_left--;
            end else if (hs >= v.ad && pt_left > 0) begin
               stall = 1;
               pt_left--;
            end
            block_valid_i = !stall;
         end else begin
            block_valid_i = 1'($urandom_range(0, 1));
         end
         @(negedge clock_i);
         if (busy_o) busy_n++;
         if (cipher_valid_o) cv++;
         if (block_ready_o && block_valid_i) hs++;
         if (enable_state_o) got_q.push_back(int'(round_o));
         if (!bypass_xor_end_o) begin
            if (xe < 3) modes[2-xe] = mode_xor_key_o;
            xe++;
         end
         if (tag_valid_o) tag_cyc = cyc;
         if (block_ready_o && !block_valid_i) begin
            if (enable_state_o !== 1'b0) bad_wait++;
            if (prev_stall && round_o !== prev_rnd) bad_wait++;
         end
         prev_stall = block_ready_o && !block_valid_i;
         prev_rnd = round_o;
         @(posedge clock_i);
         #1;
      end
      start_i = 1'b0;
      block_valid_i = 1'b0;

      if (got_q.size() != exp_q.size()) bad_rnd = 1000 + got_q.size();
      else
         for (int i = 0; i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) bad_rnd++;

      check({nm, "_tag_cycle"},   32'(tag_cyc), 32'(v.exp_tag));
      check({nm, "_busy_cycles"}, 32'(busy_n),  32'(v.exp_tag));
      check({nm, "_handshakes"},  32'(hs),      32'(v.exp_hs));
      check({nm, "_cipher"},      32'(cv),      32'(v.exp_cv));
      check({nm, "_xor_end_cnt"}, 32'(xe),      3);
      check({nm, "_xor_modes"},   32'(modes),   32'b101);
      check({nm, "_round_seq"},   32'(bad_rnd), 0);
      check({nm, "_wait_hold"},   32'(bad_wait), 0);
      @(negedge clock_i);
      check({nm, "_idle_busy"},   32'(busy_o), 0);
      check({nm, "_idle_ready"},  32'(block_ready_o), 0);
   endtask

   initial begin
      bit seen_cv;
      bit found;

      vecs[0] = '{ad: 1, pt: 1, ad_stall: 0, pt_stall: 0, restart: 0, exp_tag: 31, exp_hs: 2, exp_cv: 1};
      vecs[1] = '{ad: 2, pt: 3, ad_stall: 0, pt_stall: 0, restart: 0, exp_tag: 49, exp_hs: 5, exp_cv: 3};
      vecs[2] = '{ad: 1, pt: 1, ad_stall: 4, pt_stall: 2, restart: 0, exp_tag: 37, exp_hs: 2, exp_cv: 1};
      vecs[3] = '{ad: 3, pt: 1, ad_stall: 0, pt_stall: 0, restart: 0, exp_tag: 43, exp_hs: 4, exp_cv: 1};
      vecs[4] = '{ad: 1, pt: 2, ad_stall: 1, pt_stall: 3, restart: 0, exp_tag: 41, exp_hs: 3, exp_cv: 2};
      vecs[5] = '{ad: 1, pt: 1, ad_stall: 0, pt_stall: 0, restart: 1, exp_tag: 31, exp_hs: 2, exp_cv: 1};

      reset_i = 1'b1;
      start_i = 1'b0;
      ad_nb_i = 8'd0;
      pt_nb_i = 8'd0;
      block_valid_i = 1'b0;
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      check_idle("reset");
      reset_i = 1'b0;

      for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Zero block counts must not start a transaction
      @(negedge clock_i);
      ad_nb_i = 8'd2;
      pt_nb_i = 8'd0;
      start_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      check("zero_pt_busy", 32'(busy_o), 0);
      ad_nb_i = 8'd0;
      pt_nb_i = 8'd1;
      start_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      check("zero_ad_busy", 32'(busy_o), 0);
      check("zero_ad_round", 32'(round_o), 0);

      // Reset in the middle of finalisation
      ad_nb_i = 8'd1;
      pt_nb_i = 8'd1;
      start_i = 1'b1;
      block_valid_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      seen_cv = 0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (cipher_valid_o) seen_cv = 1;
         else if (seen_cv && round_o == 4'd5) found = 1;
         if (!found) @(negedge clock_i);
      end
      check("final_rnd5_found", 32'(found), 1);
      check("final_rnd5_enable", 32'(enable_state_o), 1);
      reset_i = 1'b1;
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
      block_valid_i = 1'b0;
      @(negedge clock_i);
      check_idle("mid_reset");
      run_txn(vecs[0], "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
